// File: rtl/mulacc_feeder.sv
// Dot-product operand sequencer: streams operand pairs from two sync-read RAMs into a MAC and captures the sum.
// `FEEDER_STRIDE_EN adds b_stride_i so the B address steps by a programmable stride (matrix column access).
module mulacc_feeder #(
  parameter int ADDR_W  = 8,
  parameter int ACC_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W:0]   len_i,
`ifdef FEEDER_STRIDE_EN
  input  logic [ADDR_W-1:0] b_stride_i,
`endif
  output logic              mem_a_rd_o,
  output logic              mem_b_rd_o,
  output logic [ADDR_W-1:0] mem_a_addr_o,
  output logic [ADDR_W-1:0] mem_b_addr_o,
  input  logic [31:0]       mem_a_data_i,
  input  logic [31:0]       mem_b_data_i,
  output logic              mac_clear_o,
  output logic              mac_next_o,
  output logic [31:0]       mac_a_o,
  output logic [31:0]       mac_b_o,
  input  logic [64:0]       mac_psum_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [64:0]       result_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // CLEAR | clear accumulator, issue first read
  // LOAD  | register returned operands
  // ISSUE | pulse mac_next, prefetch next pair
  // DRAIN | wait ACC_LAT cycles for the final sum
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [3:0]        DRN_ONE  = 4'd1;
  localparam logic [3:0]        DRN_INIT = 4'(ACC_LAT);
  localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [3:0]        drain_q, drain_d;
  logic [31:0]       mac_a_q, mac_a_d;
  logic [31:0]       mac_b_q, mac_b_d;
  logic [64:0]       result_q, result_d;
  logic [ADDR_W-1:0] b_step;
  logic              mem_rd;

`ifdef FEEDER_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stride_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      stride_q <= b_stride_i;
    end
  end

  assign b_step = stride_q;
`else
  assign b_step = ADDR_W'(1);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
    result_d     = result_q;
    mem_rd       = 1'b0;
    mac_clear_o  = 1'b0;
    mac_next_o   = 1'b0;
    done_o       = 1'b0;
    mem_a_addr_o = addr_a_q;
    mem_b_addr_o = addr_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_a_d = base_a_i;
            addr_b_d = base_b_i;
            cnt_d    = len_i;
            state_d  = S_CLEAR;
          end else begin
            result_d = '0;
            state_d  = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        mac_clear_o = 1'b1;
        mem_rd      = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        mac_a_d = mem_a_data_i;
        mac_b_d = mem_b_data_i;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mac_next_o   = 1'b1;
        cnt_d        = cnt_q - CNT_ONE;
        addr_a_d     = addr_a_q + A_STEP;
        addr_b_d     = addr_b_q + b_step;
        // Prefetch the next pair at the advanced addresses in the same cycle.
        mem_a_addr_o = addr_a_d;
        mem_b_addr_o = addr_b_d;
        if (cnt_q != CNT_ONE) begin
          mem_rd  = 1'b1;
          state_d = S_LOAD;
        end else begin
          drain_d = DRN_INIT;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRN_ONE;
        if (drain_q == DRN_ONE) begin
          result_d = mac_psum_i;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_a_rd_o = mem_rd;
  assign mem_b_rd_o = mem_rd;
  assign mac_a_o    = mac_a_q;
  assign mac_b_o    = mac_b_q;
  assign result_o   = result_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mulacc_feeder.sv
// Directed bench for mulacc_feeder with behavioural operand RAMs and a one-cycle MAC.
module tb_mulacc_feeder;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  base_a, base_b;
  logic [8:0]  len;
`ifdef FEEDER_STRIDE_EN
  logic [7:0]  b_stride;
`endif
  logic        mem_a_rd, mem_b_rd;
  logic [7:0]  mem_a_addr, mem_b_addr;
  logic [31:0] mem_a_data, mem_b_data;
  logic        mac_clear, mac_next;
  logic [31:0] mac_a, mac_b;
  logic [64:0] mac_psum;
  logic        busy, done;
  logic [64:0] result;

  always #5 clk = ~clk;

  mulacc_feeder #(.ADDR_W(8), .ACC_LAT(1)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .base_a_i(base_a), .base_b_i(base_b), .len_i(len),
`ifdef FEEDER_STRIDE_EN
    .b_stride_i(b_stride),
`endif
    .mem_a_rd_o(mem_a_rd), .mem_b_rd_o(mem_b_rd),
    .mem_a_addr_o(mem_a_addr), .mem_b_addr_o(mem_b_addr),
    .mem_a_data_i(mem_a_data), .mem_b_data_i(mem_b_data),
    .mac_clear_o(mac_clear), .mac_next_o(mac_next),
    .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_psum_i(mac_psum),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];

  always @(posedge clk) begin
    if (mem_a_rd) mem_a_data <= ram_a[mem_a_addr];
    if (mem_b_rd) mem_b_data <= ram_b[mem_b_addr];
  end

  always @(posedge clk) begin
    if (reset || mac_clear) mac_psum <= '0;
    else if (mac_next)      mac_psum <= mac_psum + (65'(mac_a) * 65'(mac_b));
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  int          clear_cnt, clear_cyc, next_cnt, done_cnt, done_cyc, busy_cnt, busy_first;
  int          next_cyc[$];
  logic [7:0]  rda[$];
  logic [7:0]  rdb[$];
  logic [64:0] res_seen;

  task automatic check_idle_zero(input string tag);
    chk({tag, "_strobes"}, 65'({busy, done, mac_clear, mac_next, mem_a_rd, mem_b_rd}), 65'd0);
    chk({tag, "_result"}, result, 65'd0);
    chk({tag, "_ops"}, 65'({mac_a, mac_b}), 65'd0);
    chk({tag, "_addr"}, 65'({mem_a_addr, mem_b_addr}), 65'd0);
  endtask

  // mode 0: plain job, 1: extra start at cycle 4, 2: reset at cycle 4
  task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [8:0] ln,
                         input int mode);
    clear_cnt = 0; clear_cyc = -1; next_cnt = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; busy_first = -1; res_seen = '0;
    next_cyc.delete(); rda.delete(); rdb.delete();
    @(negedge clk);
    base_a = ba; base_b = bb; len = ln; start = 1'b1;
    for (int k = 1; k <= 2 * int'(ln) + 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (mac_clear) begin clear_cnt++; if (clear_cyc < 0) clear_cyc = k; end
      if (mac_next) begin next_cnt++; next_cyc.push_back(k); end
      if (mem_a_rd) rda.push_back(mem_a_addr);
      if (mem_b_rd) rdb.push_back(mem_b_addr);
      if (busy) begin busy_cnt++; if (busy_first < 0) busy_first = k; end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = k; res_seen = result; end
      end
      if (mode == 1 && k == 4) start = 1'b1;
      if (mode == 1 && k == 5) start = 1'b0;
      if (mode == 2 && k == 4) reset = 1'b1;
      if (mode == 2 && k == 5) begin
        check_idle_zero("rst_mid");
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_a = '0; base_b = '0; len = '0;
`ifdef FEEDER_STRIDE_EN
    b_stride = 8'd1;
`endif
    for (int i = 0; i < 256; i++) begin ram_a[i] = '0; ram_b[i] = '0; end
    ram_a[10] = 32'd3;  ram_a[11] = 32'd7;
    ram_b[20] = 32'd5;  ram_b[21] = 32'd11;
    ram_a[30] = 32'hFFFF_FFFF; ram_a[31] = 32'hFFFF_FFFF;
    ram_b[40] = 32'hFFFF_FFFF; ram_b[41] = 32'hFFFF_FFFF;
    ram_a[255] = 32'd1; ram_a[0] = 32'd2; ram_a[1] = 32'd3;
    ram_b[255] = 32'd4; ram_b[0] = 32'd5; ram_b[1] = 32'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    // 3*5 + 7*11 = 92
    run_job(8'd10, 8'd20, 9'd2, 0);
    chk("t1_clear_cyc", 65'(clear_cyc), 65'd1);
    chk("t1_clear_cnt", 65'(clear_cnt), 65'd1);
    chk("t1_next_cnt", 65'(next_cnt), 65'd2);
    if (next_cnt == 2) begin
      chk("t1_next0", 65'(next_cyc[0]), 65'd3);
      chk("t1_next1", 65'(next_cyc[1]), 65'd5);
    end
    chk("t1_done_cyc", 65'(done_cyc), 65'd7);
    chk("t1_done_cnt", 65'(done_cnt), 65'd1);
    chk("t1_result", res_seen, 65'd92);
    chk("t1_busy_cnt", 65'(busy_cnt), 65'd7);
    chk("t1_busy_first", 65'(busy_first), 65'd1);
    chk("t1_rda_n", 65'(rda.size()), 65'd2);
    if (rda.size() == 2) chk("t1_rda", 65'({rda[0], rda[1]}), 65'h0A0B);
    chk("t1_hold", result, 65'd92);

    run_job(8'd10, 8'd20, 9'd0, 0);
    chk("t2_done_cyc", 65'(done_cyc), 65'd1);
    chk("t2_result", res_seen, 65'd0);
    chk("t2_reads", 65'(rda.size() + rdb.size()), 65'd0);
    chk("t2_clear_next", 65'(clear_cnt + next_cnt), 65'd0);

    run_job(8'd30, 8'd40, 9'd2, 0);
    chk("t3_result", res_seen, 65'h1_FFFF_FFFC_0000_0002);
    chk("t3_done_cyc", 65'(done_cyc), 65'd7);

    // 1*4 + 2*5 + 3*6 = 32 across the address wrap
    run_job(8'hFF, 8'hFF, 9'd3, 0);
    chk("t4_rda_n", 65'(rda.size()), 65'd3);
    chk("t4_rdb_n", 65'(rdb.size()), 65'd3);
    if (rda.size() == 3) chk("t4_rda", 65'({rda[0], rda[1], rda[2]}), 65'hFF0001);
    if (rdb.size() == 3) chk("t4_rdb", 65'({rdb[0], rdb[1], rdb[2]}), 65'hFF0001);
    chk("t4_result", res_seen, 65'd32);
    chk("t4_done_cyc", 65'(done_cyc), 65'd9);

    run_job(8'd10, 8'd20, 9'd2, 1);
    chk("t5_done_cnt", 65'(done_cnt), 65'd1);
    chk("t5_done_cyc", 65'(done_cyc), 65'd7);
    chk("t5_result", res_seen, 65'd92);

    run_job(8'd30, 8'd40, 9'd2, 2);
    chk("t6_done_cnt", 65'(done_cnt), 65'd0);
    chk("t6_busy_cnt", 65'(busy_cnt), 65'd4);
    run_job(8'd10, 8'd20, 9'd2, 0);
    chk("t6_after_result", res_seen, 65'd92);
    chk("t6_after_done_cyc", 65'(done_cyc), 65'd7);

`ifdef FEEDER_STRIDE_EN
    ram_a[50] = 32'd1; ram_a[51] = 32'd1; ram_a[52] = 32'd1;
    ram_b[2] = 32'd10; ram_b[6] = 32'd20; ram_b[10] = 32'd30;
    b_stride = 8'd4;
    run_job(8'd50, 8'd2, 9'd3, 0);
    if (rda.size() == 3) chk("t7_rda", 65'({rda[0], rda[1], rda[2]}), 65'h323334);
    else chk("t7_rda_n", 65'(rda.size()), 65'd3);
    if (rdb.size() == 3) chk("t7_rdb", 65'({rdb[0], rdb[1], rdb[2]}), 65'h02060A);
    else chk("t7_rdb_n", 65'(rdb.size()), 65'd3);
    chk("t7_result", res_seen, 65'd60);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
